mp_regfile: RTL and testbench
=============================

MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count (power of two, >= 4).
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 Parameter ZERO_REG, default 1, 1 = register 0 reads as zero and ignores writes.
REQ-007 Derived constant AW = clog2(NUM_REGS).
REQ-008 clk  in  1  clock, all state updates on rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 wr_en  in  NUM_WR  per-port write enable.
REQ-011 wr_addr  in  NUM_WR*AW  packed write addresses, port p at bits [p*AW +: AW].
REQ-012 wr_data  in  NUM_WR*DATA_W  packed write data.
REQ-013 rd_addr  in  NUM_RD*AW  packed read addresses.
REQ-014 rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
REQ-015 clr_req  in  1  single-cycle request to zero the whole file.
REQ-016 busy  out  1  high while a clear sequence is in progress.
REQ-017 clr_done  out  1  single-cycle pulse on completion of a clear.

Function
REQ-018 Write: when wr_en[p] is high and the file is not busy, the register at wr_addr[p] SHALL take wr_data[p] at the next rising edge.
REQ-019 Same-address writes in one cycle: the highest-numbered port SHALL win.
REQ-020 ZERO_REG=1: writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0, including under bypass.
REQ-021 BYPASS=1: a read address matching an enabled, accepted write address in the same cycle SHALL return that write data (highest port wins); otherwise the stored value.
REQ-022 BYPASS=0: reads SHALL always return the stored value (the old value during a same-cycle write).
REQ-023 Clear FSM states: IDLE, CLEAR; reset state IDLE.
REQ-024 IDLE -> CLEAR on clr_req high; clear pointer loads 0; busy rises on the following cycle.
REQ-025 In CLEAR, one register per cycle (pointer index) SHALL be zeroed and the pointer incremented.
REQ-026 CLEAR -> IDLE after zeroing register NUM_REGS-1: busy falls and clr_done pulses for exactly one cycle.
REQ-027 A clear SHALL take exactly NUM_REGS cycles with busy high.
REQ-028 In CLEAR: all writes SHALL be ignored (no forwarding); clr_req SHALL be ignored; reads SHALL return current stored contents.
REQ-029 clr_req and wr_en together in IDLE: the write SHALL complete, then the clear begins.

Reset
REQ-030 On rst_n low, all registers SHALL be 0, FSM IDLE, pointer 0, busy 0, clr_done 0, immediately and independent of clk.
REQ-031 Reset during CLEAR SHALL abort the sequence, with no clr_done pulse.
REQ-032 After rst_n deasserts, the first rising edge SHALL accept writes normally.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (IDLE=0, CLEAR=1) and the clog2 helper.
REQ-034 The forwarding/priority mux per read port SHALL be one sub-module, rf_read_mux, instantiated NUM_RD times.
REQ-035 Storage SHALL be flops, not inferred RAM; implementation 120-400 RTL lines.

Verification
REQ-036 Write: port0 writes r5=0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF.
REQ-037 Collision: port0 r7=0x1, port1 r7=0x2 same cycle -> r7=0x2; with BYPASS=1 the same-cycle read of 7 returns 0x2.
REQ-038 Zero register: write r0=0xFFFFFFFF -> read r0=0 that cycle and after.
REQ-039 Clear: fill all regs with nonzero values, pulse clr_req -> busy high 32 cycles, clr_done one cycle, then all reads 0; a write to r3=0x55 during busy -> r3 still 0.
REQ-040 Reset mid-clear: rst_n low at clear cycle 10 -> busy=0, no clr_done, all regs 0.
REQ-041 BYPASS=0 build: write r9=0xA while reading r9 (old 0x3) -> rd_data=0x3, next cycle 0xA.

Source files
------------

// File: rtl/mp_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mp_regfile_pkg : clear-FSM state encoding and clog2 helper            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mp_regfile_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mp_regfile_read_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_read_mux : one read port, write forwarding and zero-register mask  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_read_mux #(
   parameter int DATA_W   = 32,
   parameter int AW       = 5,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [AW-1:0]            rd_addr,
   input  logic [DATA_W-1:0]        stored,
   input  logic [NUM_WR-1:0]        wr_ok,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] w_fwd;

   generate
      if (BYPASS != 0) begin : g_bypass
         // Later ports overwrite earlier matches so the highest port wins.
         always_comb begin
            w_fwd = stored;
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_ok[p] && (wr_addr[p*AW +: AW] == rd_addr))
                  w_fwd = wr_data[p*DATA_W +: DATA_W];
            end
         end
      end else begin : g_no_bypass
         logic w_unused_wr;
         assign w_unused_wr = ^{wr_ok, wr_addr, wr_data};
         assign w_fwd = stored;
      end
   endgenerate

   assign rd_data = ((ZERO_REG != 0) && (rd_addr == '0)) ? '0 : w_fwd;

endmodule
`default_nettype wire

// File: rtl/mp_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mp_regfile : multi-port flop register file with sequential clear      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mp_regfile
   import mp_regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   parameter int AW       = clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);

   localparam logic [AW-1:0] c_LAST = AW'(NUM_REGS - 1);
   localparam logic [AW-1:0] c_ONE  = AW'(1);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [0:0]        r_state;
   logic [AW-1:0]     r_ptr;
   logic              r_clr_done;
   logic [NUM_WR-1:0] w_wr_ok;

   // A write is accepted only outside a clear and never to a hard-wired zero.
   generate
      for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_ok
         assign w_wr_ok[p] = wr_en[p] && (r_state == ST_IDLE) &&
                             !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_clr_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clr_req) begin
                  r_state <= ST_CLEAR;
                  r_ptr   <= '0;
               end
            end
            ST_CLEAR: begin
               r_ptr <= r_ptr + c_ONE;
               if (r_ptr == c_LAST) begin
                  r_state    <= ST_IDLE;
                  r_clr_done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_regs[r_ptr] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (w_wr_ok[p])
               r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*DATA_W +: DATA_W];
         end
      end
   end

   generate
      for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
         rf_read_mux #(
            .DATA_W   (DATA_W),
            .AW       (AW),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
         ) u_mux (
            .rd_addr (rd_addr[r*AW +: AW]),
            .stored  (r_regs[rd_addr[r*AW +: AW]]),
            .wr_ok   (w_wr_ok),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[r*DATA_W +: DATA_W])
         );
      end
   endgenerate

   assign busy     = (r_state == ST_CLEAR);
   assign clr_done = r_clr_done;

endmodule
`default_nettype wire

// File: tb/tb_mp_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mp_regfile : directed self-checking bench, bypass and no-bypass    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mp_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [63:0] rd_data_nb;
   logic        clr_req;
   logic        busy, busy_nb;
   logic        clr_done, clr_done_nb;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mp_regfile dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   mp_regfile #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .clr_req(clr_req), .busy(busy_nb), .clr_done(clr_done_nb)
   );

   task automatic idle_inputs();
      wr_en   = 2'b00;
      clr_req = 1'b0;
   endtask

   task automatic fill_all();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wr_en   = 2'b11;
         wr_addr = {5'(2*i+1), 5'(2*i)};
         wr_data = {32'h100 + 32'(2*i+1), 32'h100 + 32'(2*i)};
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      wr_addr = '0; wr_data = '0; rd_addr = {5'd31, 5'd5};
      #3;
      n_vec++;
      if (busy !== 1'b0 || clr_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl busy=%b clr_done=%b want 0/0", busy, clr_done);
      end
      n_vec++;
      if (rd_data !== 64'h0) begin
         n_err++;
         $display("FAIL reset_rd got %h want 0", rd_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      @(negedge clk);
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      rd_addr = {5'd6, 5'd5};
      #1;
      n_vec++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL write_fwd got %h want deadbeef", rd_data[31:0]);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_data[31:0] !== 32'hDEADBEEF || rd_data_nb[31:0] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL write_stored got %h/%h want deadbeef", rd_data[31:0], rd_data_nb[31:0]);
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2, 32'h1};
      rd_addr = {5'd7, 5'd7};
      #1;
      n_vec++;
      if (rd_data !== {32'h2, 32'h2}) begin
         n_err++;
         $display("FAIL collide_fwd got %h want 2/2", rd_data);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_data !== {32'h2, 32'h2} || rd_data_nb !== {32'h2, 32'h2}) begin
         n_err++;
         $display("FAIL collide_stored got %h/%h want 2", rd_data, rd_data_nb);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      wr_en = 2'b01; wr_addr = {5'd1, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
      rd_addr = {5'd0, 5'd0};
      #1;
      n_vec++;
      if (rd_data !== 64'h0) begin
         n_err++;
         $display("FAIL zero_fwd got %h want 0", rd_data);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
         n_err++;
         $display("FAIL zero_stored got %h/%h want 0", rd_data, rd_data_nb);
      end
   endtask

   task automatic test_no_bypass();
      @(negedge clk);
      wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h3};
      @(negedge clk);
      wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'hA, 32'h0};
      rd_addr = {5'd9, 5'd9};
      #1;
      n_vec++;
      if (rd_data_nb[31:0] !== 32'h3 || rd_data[31:0] !== 32'hA) begin
         n_err++;
         $display("FAIL nobyp_same got nb=%h byp=%h want 3/a", rd_data_nb[31:0], rd_data[31:0]);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (rd_data_nb[31:0] !== 32'hA) begin
         n_err++;
         $display("FAIL nobyp_next got %h want a", rd_data_nb[31:0]);
      end
   endtask

   task automatic test_clear();
      int busy_cnt, done_cnt, cyc;
      logic late_done;
      fill_all();
      rd_addr = {5'd31, 5'd3};
      #1;
      n_vec++;
      if (rd_data !== {32'h11F, 32'h103}) begin
         n_err++;
         $display("FAIL fill got %h want 0000011f00000103", rd_data);
      end
      // Clear request together with a write: the write lands first.
      @(negedge clk);
      clr_req = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44};
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL clr_busy_early got %b want 0", busy);
      end
      busy_cnt = 0; done_cnt = 0; cyc = 0; late_done = 1'b0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55};
            clr_req = 1'b1; rd_addr = {5'd4, 5'd3};
            #1;
            n_vec++;
            if (rd_data !== {32'h44, 32'h103}) begin
               n_err++;
               $display("FAIL clr_first_cycle got %h want 00000044/00000103", rd_data);
            end
         end else begin
            idle_inputs();
            #1;
         end
         if (busy) busy_cnt++;
         if (clr_done) begin
            done_cnt++;
            if (busy) late_done = 1'b1;
         end
         if (!busy && cyc > 1 && clr_done === 1'b0 && done_cnt > 0) break;
      end
      n_vec++;
      if (busy_cnt != 32) begin
         n_err++;
         $display("FAIL clr_busy_len got %0d want 32", busy_cnt);
      end
      n_vec++;
      if (done_cnt != 1 || late_done) begin
         n_err++;
         $display("FAIL clr_done_pulse got %0d pulses overlap=%b want 1/0", done_cnt, late_done);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = {5'(2*i+1), 5'(2*i)};
         #1;
         n_vec++;
         if (rd_data !== 64'h0) begin
            n_err++;
            $display("FAIL clr_contents r%0d/r%0d got %h want 0", 2*i, 2*i+1, rd_data);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int seen;
      fill_all();
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      seen = 1;
      while (seen < 10) begin
         @(negedge clk);
         seen++;
      end
      rst_n = 1'b0;
      rd_addr = {5'd31, 5'd20};
      #1;
      n_vec++;
      if (busy !== 1'b0 || rd_data !== 64'h0) begin
         n_err++;
         $display("FAIL rst_mid busy=%b rd=%h want 0/0", busy, rd_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h66};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         n_vec++;
         if (clr_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done cyc%0d done=%b busy=%b want 0/0", i, clr_done, busy);
         end
      end
      rd_addr = {5'd20, 5'd6};
      #1;
      n_vec++;
      if (rd_data !== {32'h0, 32'h66}) begin
         n_err++;
         $display("FAIL rst_first_write got %h want 0000000000000066", rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_collision();
      test_zero_reg();
      test_no_bypass();
      test_clear();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
